// File: rtl/vga_sync_decoder_if.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder_if
// Bundles the raw sync inputs and the recovered timing outputs of the VGA
// sync decoder.
//   master : the side that sources HSync/VSync and consumes the results
//   slave  : the decoder itself
// Signals
//   i_HSync, i_VSync : raw active-low syncs (asynchronous to i_Clk)
//   o_X, o_Y         : recovered visible column/row, 0 outside the window
//   o_Active         : locked and inside the visible window
//   o_Locked         : timing lock flag
//   o_Line_Clocks    : last measured line length in clocks
//   o_Frame_Lines    : last measured frame length in lines
//   o_Err_Count      : lock-loss counter (0 unless VGA_SYNC_ERR_CNT_EN)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface vga_sync_decoder_if;
    logic        i_HSync;
    logic        i_VSync;
    logic [11:0] o_X;
    logic [11:0] o_Y;
    logic        o_Active;
    logic        o_Locked;
    logic [11:0] o_Line_Clocks;
    logic [11:0] o_Frame_Lines;
    logic [7:0]  o_Err_Count;

    modport master (
        output i_HSync, i_VSync,
        input  o_X, o_Y, o_Active, o_Locked,
               o_Line_Clocks, o_Frame_Lines, o_Err_Count
    );

    modport slave (
        input  i_HSync, i_VSync,
        output o_X, o_Y, o_Active, o_Locked,
               o_Line_Clocks, o_Frame_Lines, o_Err_Count
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
// Receive-side VGA timing recovery. Synchronises raw HSync/VSync, counts
// clocks per line and lines per frame from the sync falling edges, checks
// them against the expected timing and raises a lock flag after one full
// matching frame. While locked it reports the visible pixel coordinate.
// Ports
//   i_Clk   : pixel clock
//   w_Reset : synchronous, active-high reset
//   bus     : vga_sync_decoder_if.slave (syncs in, coordinates/timing out)
// Optional feature
//   VGA_SYNC_ERR_CNT_EN : when defined, o_Err_Count counts LOCKED->SEARCH
//                         transitions (saturating at 255); otherwise it is 0.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_sync_decoder #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int LINE_TOL    = 2
) (
    input  logic                i_Clk,
    input  logic                w_Reset,
    vga_sync_decoder_if.slave   bus
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [12:0] LINE_MAX = 13'(TOTAL_COLS + LINE_TOL);
    localparam logic [12:0] LINE_MIN = 13'(TOTAL_COLS - LINE_TOL);
    localparam logic [12:0] ROWS_OK  = 13'(TOTAL_ROWS);
    localparam logic [12:0] TIMEOUT  = 13'(2 * TOTAL_COLS);
    localparam logic [11:0] H_FIRST  = 12'(H_START);
    localparam logic [11:0] H_LAST   = 12'(H_START + ACTIVE_COLS - 1);
    localparam logic [11:0] V_FIRST  = 12'(V_START);
    localparam logic [11:0] V_LAST   = 12'(V_START + ACTIVE_ROWS - 1);

    // -----------------------------------------------------------------------
    // Sync capture: two flops against metastability, a third for edge detect
    // -----------------------------------------------------------------------
    logic hs_meta, hs_sync, hs_prev;
    logic vs_meta, vs_sync, vs_prev;

    // NOTE: synchronizer flops reset to 1 (the idle sync level) so that
    // leaving reset never looks like a falling edge.
    always_ff @(posedge i_Clk) begin
        if (w_Reset) begin
            hs_meta <= 1'b1;
            hs_sync <= 1'b1;
            hs_prev <= 1'b1;
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the three stages shift
            // together; blocking ones would collapse the chain into one flop.
            hs_meta <= bus.i_HSync;
            hs_sync <= hs_meta;
            hs_prev <= hs_sync;
            vs_meta <= bus.i_VSync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    logic hs_fall, vs_fall;
    assign hs_fall = hs_prev & ~hs_sync;
    assign vs_fall = vs_prev & ~vs_sync;

    // -----------------------------------------------------------------------
    // Counters and measurements
    // -----------------------------------------------------------------------
    logic [11:0] hc, vc;
    logic        hs_seen, vs_seen;
    logic [11:0] line_clocks, frame_lines;

    logic [12:0] line_len, frame_len;
    logic        line_fail, frame_ok, frame_fail, timeout, in_window;

    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        line_len   = {1'b0, hc} + 13'd1;
        frame_len  = {1'b0, vc} + 13'd1;
        line_fail  = 1'b0;
        frame_ok   = 1'b0;
        frame_fail = 1'b0;
        if (hs_fall && hs_seen)
            line_fail = (line_len > LINE_MAX) || (line_len < LINE_MIN);
        if (vs_fall && vs_seen) begin
            frame_ok   = (frame_len == ROWS_OK);
            frame_fail = !frame_ok;
        end
        // A missing HSync keeps the count climbing until this trips.
        timeout   = !hs_fall && ({1'b0, hc} >= TIMEOUT);
        in_window = (hc >= H_FIRST) && (hc <= H_LAST) &&
                    (vc >= V_FIRST) && (vc <= V_LAST);
    end

    always_ff @(posedge i_Clk) begin
        if (w_Reset) begin
            hc          <= '0;
            vc          <= '0;
            hs_seen     <= 1'b0;
            vs_seen     <= 1'b0;
            line_clocks <= '0;
            frame_lines <= '0;
        end else begin
            if (hs_fall)
                hc <= '0;
            else if (hc != '1)
                hc <= hc + 12'd1;

            // VSync wins over a coincident HSync so the frame starts at row 0.
            if (vs_fall)
                vc <= '0;
            else if (hs_fall && vc != '1)
                vc <= vc + 12'd1;

            if (hs_fall) hs_seen <= 1'b1;
            if (vs_fall) vs_seen <= 1'b1;

            if (hs_fall && hs_seen) line_clocks <= line_len[11:0];
            if (vs_fall && vs_seen) frame_lines <= frame_len[11:0];
        end
    end

    // -----------------------------------------------------------------------
    // Lock FSM with registered outputs
    // -----------------------------------------------------------------------
    state_t      state;
    logic        locked, active;
    logic [11:0] pix_x, pix_y;

    always_ff @(posedge i_Clk) begin
        if (w_Reset) begin
            state  <= SEARCH;
            locked <= 1'b0;
            active <= 1'b0;
            pix_x  <= '0;
            pix_y  <= '0;
        end else begin
            // Outputs follow the current state, so they trail it by a clock.
            locked <= (state == LOCKED);
            active <= (state == LOCKED) && in_window;
            pix_x  <= ((state == LOCKED) && in_window) ? hc - H_FIRST : '0;
            pix_y  <= ((state == LOCKED) && in_window) ? vc - V_FIRST : '0;

            case (state)
                SEARCH: begin
                    if (vs_fall) state <= MEASURE;
                end
                MEASURE: begin
                    if (line_fail || timeout)
                        state <= SEARCH;
                    else if (frame_ok)
                        state <= LOCKED;
                    // A bad frame length simply starts a fresh measurement.
                end
                LOCKED: begin
                    if (line_fail || frame_fail || timeout) state <= SEARCH;
                end
                default: state <= SEARCH;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Optional lock-loss counter
    // -----------------------------------------------------------------------
`ifdef VGA_SYNC_ERR_CNT_EN
    logic [7:0] err_count;
    logic       lock_lost;

    assign lock_lost = (state == LOCKED) && (line_fail || frame_fail || timeout);

    always_ff @(posedge i_Clk) begin
        if (w_Reset)
            err_count <= '0;
        else if (lock_lost && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end

    assign bus.o_Err_Count = err_count;
`else
    assign bus.o_Err_Count = 8'd0;
`endif

    assign bus.o_X           = pix_x;
    assign bus.o_Y           = pix_y;
    assign bus.o_Active      = active;
    assign bus.o_Locked      = locked;
    assign bus.o_Line_Clocks = line_clocks;
    assign bus.o_Frame_Lines = frame_lines;

endmodule
